aes_ecb_pipe: RTL and testbench



---
 rtl/aes_ecb_pipe.sv | 192 +++++++++++++++++++
 tb/tb_aes_ecb_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_pipe.sv
// aes_ecb_pipe: per-beat XOR-with-key / invert transform on an Avalon-ST
// datapath. Includes a per-packet loadable key, a fixed-depth register
// pipeline, an elastic first-word-fall-through output FIFO, SOP/EOP framing
// check and an egress packet counter.
module aes_ecb_pipe #(
  parameter int DATA_W       = 128,
  parameter int PIPE_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16,
  localparam int EMPTY_W     = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  // ingress
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               data_in_sop,
  input  logic               data_in_eop,
  input  logic [EMPTY_W-1:0] data_in_empty,
  input  logic [DATA_W-1:0]  data_in_data,
  // egress
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               data_out_sop,
  output logic               data_out_eop,
  output logic [EMPTY_W-1:0] data_out_empty,
  output logic [DATA_W-1:0]  data_out_data,
  // key control and status
  input  logic [DATA_W-1:0]  key_in,
  input  logic               mode_in,
  input  logic               key_load,
  output logic               key_pending,
  output logic               proto_err,
  output logic [CNT_W-1:0]   pkt_cnt
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both 1. A master holds valid and all fields stable until it transfers;
  // ready may change freely and never depends combinationally on valid.
  // data_in_ready is a function of registered state only.

  localparam int BEAT_W = DATA_W + EMPTY_W + 2;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

  generate
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
      $error("aes_ecb_pipe: DATA_W must be a multiple of 8 and at least 8");
    end
    if (PIPE_STAGES < 1) begin : g_bad_pipe
      $error("aes_ecb_pipe: PIPE_STAGES must be at least 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("aes_ecb_pipe: FIFO_DEPTH must be at least 2");
    end
  endgenerate

  logic [DATA_W-1:0] key_act;
  logic [DATA_W-1:0] key_pend;
  logic              mode_act;
  logic              mode_pend;
  logic              in_pkt;
  logic [OCC_W-1:0]  occ;

  logic              key_stall;
  logic              key_apply;
  logic              in_accept;
  logic              out_accept;
  logic [DATA_W-1:0] xform_data;
  logic [BEAT_W-1:0] in_beat;

  logic [PIPE_STAGES-1:0] st_valid;
  logic [BEAT_W-1:0]      st_beat [PIPE_STAGES];

  logic [BEAT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  fifo_cnt;
  logic              fifo_push;
  logic              fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) ptr_next = '0;
    else                             ptr_next = p + PTR_W'(1);
  endfunction

  // A pending key is applied only between packets, and ingress pauses for
  // the cycle in which the swap happens.
  assign key_stall     = key_pending & ~in_pkt;
  assign key_apply     = key_stall & ~key_load;
  assign data_in_ready = (occ < OCC_W'(FIFO_DEPTH)) & ~key_stall;
  assign in_accept     = data_in_valid & data_in_ready;
  assign out_accept    = data_out_valid & data_out_ready;

  assign xform_data = mode_act ? ~data_in_data : (data_in_data ^ key_act);
  assign in_beat    = {data_in_sop, data_in_eop, data_in_empty, xform_data};

  assign fifo_push      = st_valid[PIPE_STAGES-1];
  assign fifo_pop       = out_accept;
  assign data_out_valid = (fifo_cnt != '0);
  assign {data_out_sop, data_out_eop, data_out_empty, data_out_data} = fifo_mem[rd_ptr];

  // Pending/active key registers; a load in the apply cycle defers the apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_act     <= '1;
      mode_act    <= 1'b0;
      key_pend    <= '0;
      mode_pend   <= 1'b0;
      key_pending <= 1'b0;
    end else if (key_load) begin
      key_pend    <= key_in;
      mode_pend   <= mode_in;
      key_pending <= 1'b1;
    end else if (key_apply) begin
      key_act     <= key_pend;
      mode_act    <= mode_pend;
      key_pending <= 1'b0;
    end
  end

  // Framing tracker and sticky protocol error on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pkt    <= 1'b0;
      proto_err <= 1'b0;
    end else if (in_accept) begin
      if ((data_in_sop && in_pkt) || (!data_in_sop && !in_pkt)) proto_err <= 1'b1;
      if (data_in_eop)      in_pkt <= 1'b0;
      else if (data_in_sop) in_pkt <= 1'b1;
    end
  end

  // Beats held by the block, in flight plus stored; bounds ingress so the
  // pipeline can always drain into the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= '0;
    end else begin
      case ({in_accept, out_accept})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Pipeline valid tags; stages never stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid <= '0;
    end else begin
      st_valid[0] <= in_accept;
      for (int i = 1; i < PIPE_STAGES; i++) st_valid[i] <= st_valid[i-1];
    end
  end

  // Pipeline payload; qualified by st_valid so no reset is needed.
  always_ff @(posedge clk) begin
    st_beat[0] <= in_beat;
    for (int i = 1; i < PIPE_STAGES; i++) st_beat[i] <= st_beat[i-1];
  end

  // FIFO pointers and fill count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_next(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= st_beat[PIPE_STAGES-1];
  end

  // Count packets completed at egress; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)                       pkt_cnt <= '0;
    else if (out_accept && data_out_eop) pkt_cnt <= pkt_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_aes_ecb_pipe.sv
// tb_aes_ecb_pipe: directed-vector bench for aes_ecb_pipe at default
// parameters. Egress beats are scored against an expected queue filled by
// the ingress driver with hand-computed transformed values.
module tb_aes_ecb_pipe;
  localparam int DATA_W  = 128;
  localparam int EMPTY_W = 4;
  localparam int CNT_W   = 16;
  localparam int W       = DATA_W + EMPTY_W + 2;

  localparam logic [127:0] D_A    = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D_A_N  = 128'hFEDCBA9876543210_FEDCBA9876543210; // ~D_A
  localparam logic [127:0] KEY1   = 128'h00FF00FF00FF00FF_00FF00FF00FF00FF;
  localparam logic [127:0] D_A_K1 = 128'h01DC45988954CD10_01DC45988954CD10; // D_A ^ KEY1
  localparam logic [127:0] ONE_K1 = 128'hFF00FF00FF00FF00_FF00FF00FF00FF00; // '1 ^ KEY1
  localparam logic [127:0] KEY2   = 128'hFFFF0000FFFF0000_FFFF0000FFFF0000;
  localparam logic [127:0] D_A_K2 = 128'hFEDC45677654CDEF_FEDC45677654CDEF; // D_A ^ KEY2
  localparam logic [127:0] ONE_K2 = 128'h0000FFFF0000FFFF_0000FFFF0000FFFF; // '1 ^ KEY2
  localparam logic [127:0] ALL1   = '1;

  logic               clk;
  logic               rst_n;
  logic               data_in_valid;
  logic               data_in_ready;
  logic               data_in_sop;
  logic               data_in_eop;
  logic [EMPTY_W-1:0] data_in_empty;
  logic [DATA_W-1:0]  data_in_data;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               data_out_sop;
  logic               data_out_eop;
  logic [EMPTY_W-1:0] data_out_empty;
  logic [DATA_W-1:0]  data_out_data;
  logic [DATA_W-1:0]  key_in;
  logic               mode_in;
  logic               key_load;
  logic               key_pending;
  logic               proto_err;
  logic [CNT_W-1:0]   pkt_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Backpressure packet: data i+1, expected KEY2 ^ (i+1).
  logic [127:0] bp_exp [6] = '{
    128'hFFFF0000FFFF0000_FFFF0000FFFF0001,
    128'hFFFF0000FFFF0000_FFFF0000FFFF0002,
    128'hFFFF0000FFFF0000_FFFF0000FFFF0003,
    128'hFFFF0000FFFF0000_FFFF0000FFFF0004,
    128'hFFFF0000FFFF0000_FFFF0000FFFF0005,
    128'hFFFF0000FFFF0000_FFFF0000FFFF0006
  };

  aes_ecb_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_in_sop    (data_in_sop),
    .data_in_eop    (data_in_eop),
    .data_in_empty  (data_in_empty),
    .data_in_data   (data_in_data),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_sop   (data_out_sop),
    .data_out_eop   (data_out_eop),
    .data_out_empty (data_out_empty),
    .data_out_data  (data_out_data),
    .key_in         (key_in),
    .mode_in        (mode_in),
    .key_load       (key_load),
    .key_pending    (key_pending),
    .proto_err      (proto_err),
    .pkt_cnt        (pkt_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every egress handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && data_out_valid && data_out_ready) begin
      chk("egress_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0)
        chk("egress_beat", {data_out_sop, data_out_eop, data_out_empty, data_out_data},
            exp_q.pop_front());
    end
  end

  // Driver tasks (all start and end at posedge+1)
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic s, input logic e,
                           input logic [EMPTY_W-1:0] emp, input logic [127:0] xd,
                           output int waits);
    waits         = 0;
    data_in_valid = 1'b1;
    data_in_data  = d;
    data_in_sop   = s;
    data_in_eop   = e;
    data_in_empty = emp;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_in_ready) break;
      waits++;
    end
    chk("accept_in_budget", W'(data_in_ready), W'(1));
    if (data_in_ready) begin
      @(posedge clk);
      exp_q.push_back({s, e, emp, xd});
      #1;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k, input logic m);
    key_in   = k;
    mode_in  = m;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", W'(exp_q.size()), W'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int lat;
    int idx;
    int total;
    logic rdy;
    logic [127:0] d;

    data_in_valid  = 1'b0;
    data_in_sop    = 1'b0;
    data_in_eop    = 1'b0;
    data_in_empty  = '0;
    data_in_data   = '0;
    data_out_ready = 1'b1;
    key_in         = '0;
    mode_in        = 1'b0;
    key_load       = 1'b0;
    do_reset(3);

    // Reset defaults
    chk("rst_out_valid", W'(data_out_valid), W'(0));
    chk("rst_in_ready", W'(data_in_ready), W'(1));
    chk("rst_key_pending", W'(key_pending), W'(0));
    chk("rst_proto_err", W'(proto_err), W'(0));
    chk("rst_pkt_cnt", W'(pkt_cnt), W'(0));

    // Single beat, default key inverts; latency PIPE_STAGES+1
    send_beat(D_A, 1'b1, 1'b1, 4'd5, D_A_N, w);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (data_out_valid) break;
    end
    chk("latency", W'(lat), W'(3));
    drain();
    chk("pkt_cnt_1", W'(pkt_cnt), W'(1));

    // Key load between packets: one-cycle stall, then XOR with KEY1
    load_key(KEY1, 1'b0);
    chk("key_pending_set", W'(key_pending), W'(1));
    chk("key_stall_ready", W'(data_in_ready), W'(0));
    send_beat(D_A, 1'b1, 1'b0, 4'd0, D_A_K1, w);
    chk("key_stall_cycles", W'(w), W'(1));
    chk("key_pending_clear", W'(key_pending), W'(0));
    send_beat('0, 1'b0, 1'b0, 4'd0, KEY1, w);
    send_beat(ALL1, 1'b0, 1'b1, 4'd0, ONE_K1, w);
    drain();
    chk("pkt_cnt_2", W'(pkt_cnt), W'(2));

    // Key load mid-packet: rest of packet keeps KEY1, next packet uses KEY2
    send_beat(D_A, 1'b1, 1'b0, 4'd0, D_A_K1, w);
    key_in   = KEY2;
    mode_in  = 1'b0;
    key_load = 1'b1;
    send_beat('0, 1'b0, 1'b0, 4'd0, KEY1, w);
    key_load = 1'b0;
    chk("mid_pkt_no_stall", W'(w), W'(0));
    chk("mid_pkt_pending", W'(key_pending), W'(1));
    send_beat(ALL1, 1'b0, 1'b0, 4'd0, ONE_K1, w);
    send_beat(D_A, 1'b0, 1'b1, 4'd0, D_A_K1, w);
    chk("post_eop_stall", W'(data_in_ready), W'(0));
    send_beat(D_A, 1'b1, 1'b0, 4'd0, D_A_K2, w);
    chk("new_key_stall", W'(w), W'(1));
    send_beat('0, 1'b0, 1'b1, 4'd0, KEY2, w);
    drain();
    chk("pkt_cnt_4", W'(pkt_cnt), W'(4));

    // Backpressure: exactly FIFO_DEPTH accepts while egress is stalled
    data_out_ready = 1'b0;
    idx            = 0;
    data_in_valid  = 1'b1;
    data_in_sop    = 1'b1;
    data_in_eop    = 1'b0;
    data_in_empty  = '0;
    data_in_data   = 128'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = data_in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({data_in_sop, data_in_eop, data_in_empty, bp_exp[idx]});
        idx++;
      end
      #1;
      data_in_sop  = 1'b0;
      data_in_data = 128'(idx + 1);
    end
    chk("bp_accepts", W'(idx), W'(4));
    chk("bp_ready_low", W'(data_in_ready), W'(0));
    chk("bp_out_valid", W'(data_out_valid), W'(1));
    chk("bp_out_hold", W'(data_out_data), W'(bp_exp[0]));
    data_out_ready = 1'b1;
    send_beat(128'd5, 1'b0, 1'b0, 4'd0, bp_exp[4], w);
    send_beat(128'd6, 1'b0, 1'b1, 4'd0, bp_exp[5], w);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      d = {4{32'(i * 16'h1111)}};
      send_beat(d, i == 0, i == 7, 4'd0, d ^ KEY2, w);
      total += w;
    end
    chk("throughput_waits", W'(total), W'(0));
    drain();
    chk("pkt_cnt_6", W'(pkt_cnt), W'(6));

    // Protocol errors: second sop inside a packet, then a stray non-sop beat
    send_beat(D_A, 1'b1, 1'b0, 4'd0, D_A_K2, w);
    chk("proto_first_sop", W'(proto_err), W'(0));
    send_beat('0, 1'b1, 1'b0, 4'd0, KEY2, w);
    chk("proto_second_sop", W'(proto_err), W'(1));
    send_beat(ALL1, 1'b0, 1'b1, 4'd0, ONE_K2, w);
    send_beat(D_A, 1'b0, 1'b1, 4'd0, D_A_K2, w);
    drain();
    chk("proto_sticky", W'(proto_err), W'(1));
    chk("pkt_cnt_8", W'(pkt_cnt), W'(8));

    // Reset with three beats buffered
    data_out_ready = 1'b0;
    send_beat(D_A, 1'b1, 1'b0, 4'd0, D_A_K2, w);
    send_beat('0, 1'b0, 1'b0, 4'd0, KEY2, w);
    send_beat(ALL1, 1'b0, 1'b0, 4'd0, ONE_K2, w);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", W'(data_out_valid), W'(1));
    do_reset(1);
    data_out_ready = 1'b1;
    chk("post_rst_valid", W'(data_out_valid), W'(0));
    chk("post_rst_pkt_cnt", W'(pkt_cnt), W'(0));
    chk("post_rst_proto", W'(proto_err), W'(0));
    chk("post_rst_ready", W'(data_in_ready), W'(1));
    send_beat(D_A, 1'b1, 1'b1, 4'd0, D_A_N, w);
    drain();
    chk("post_rst_pkt_cnt_1", W'(pkt_cnt), W'(1));
    chk("post_rst_proto_clean", W'(proto_err), W'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_stale", W'(data_out_valid), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
